// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the single-port RAM.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport arb (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport host (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port RAM, one access per 2 cycles.
// Define MEM_ARB_RR_EN for round-robin contention; default is D-priority with a fetch starvation guard.
module mem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  mem_arbiter_if.arb bus
);
  typedef enum logic {IDLE, RESP} state_e;
  typedef enum logic {OWN_I, OWN_D} own_e;

  state_e state_q;
  own_e   own_q;
  own_e   gnt_d;
  logic   we_q;
  logic   contested, any_req, issue, resp;

`ifdef MEM_ARB_RR_EN
  own_e   last_q;
`else
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;
`endif

  assign contested = bus.i_req & bus.d_req;
  assign any_req   = bus.i_req | bus.d_req;
  // Reset gates every output so nothing leaks while rst is high, including a pending ack.
  assign issue     = !rst && (state_q == IDLE) && any_req;
  assign resp      = !rst && (state_q == RESP);

  always_comb begin
    gnt_d = OWN_I;
    if (contested) begin
`ifdef MEM_ARB_RR_EN
      gnt_d = (last_q == OWN_I) ? OWN_D : OWN_I;
`else
      gnt_d = (wait_cnt_q == WAIT_LIM) ? OWN_I : OWN_D;
`endif
    end else if (bus.d_req) begin
      gnt_d = OWN_D;
    end
  end

`ifndef MEM_ARB_RR_EN
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (gnt_d == OWN_I)
      wait_cnt_d = 4'd0;
    else if (contested && wait_cnt_q < WAIT_LIM)
      wait_cnt_d = wait_cnt_q + 4'd1;
  end
`endif

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (issue) begin
      bus.mem_en = 1'b1;
      if (gnt_d == OWN_D) begin
        bus.mem_we    = bus.d_we;
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
      end else begin
        bus.mem_addr  = bus.i_addr;
      end
    end
  end

  assign bus.i_ack   = resp && (own_q == OWN_I);
  assign bus.d_ack   = resp && (own_q == OWN_D);
  assign bus.i_rdata = bus.i_ack ? bus.mem_rdata : '0;
  assign bus.d_rdata = (bus.d_ack && !we_q) ? bus.mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= OWN_I;
      we_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q  <= OWN_I;
`else
      wait_cnt_q <= 4'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= RESP;
            own_q   <= gnt_d;
            we_q    <= (gnt_d == OWN_D) && bus.d_we;
`ifdef MEM_ARB_RR_EN
            last_q  <= gnt_d;
`else
            wait_cnt_q <= wait_cnt_d;
`endif
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with an in-bench transaction-level model and directed anchors.
module tb_mem_arbiter;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] gnt_log[$];
  bit seen_i_ack, seen_d_ack;

  // Model state: is a response owed this cycle, to whom, and how many contests fetch has lost.
  bit m_resp = 0;
  bit m_own = 0;      // 1 = data port
  bit m_we = 0;
  bit m_last = 0;     // last winner, 1 = data port
  int m_loss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    logic e_en, e_we, e_ia, e_da;
    logic [31:0] e_addr, e_wd, e_ir, e_dr;
    bit g;
    e_en = 0; e_we = 0; e_ia = 0; e_da = 0;
    e_addr = 0; e_wd = 0; e_ir = 0; e_dr = 0;
    seen_i_ack = bus.i_ack;
    seen_d_ack = bus.d_ack;
    if (bus.mem_en) gnt_log.push_back(bus.mem_addr);
    if (rst) begin
      m_resp = 0; m_loss = 0; m_last = 0;
    end else if (m_resp) begin
      if (m_own) begin
        e_da = 1;
        if (!m_we) e_dr = bus.mem_rdata;
      end else begin
        e_ia = 1;
        e_ir = bus.mem_rdata;
      end
      m_resp = 0;
    end else if (bus.i_req || bus.d_req) begin
      if (bus.i_req && bus.d_req) begin
`ifdef MEM_ARB_RR_EN
        g = !m_last;
`else
        g = (m_loss < MAX_WAIT);
`endif
        if (g) m_loss = (m_loss < MAX_WAIT) ? m_loss + 1 : MAX_WAIT;
      end else begin
        g = bus.d_req;
      end
      if (!g) m_loss = 0;
      m_last = g;
      e_en = 1;
      if (g) begin
        e_we = bus.d_we; e_addr = bus.d_addr; e_wd = bus.d_wdata;
      end else begin
        e_addr = bus.i_addr;
      end
      m_resp = 1; m_own = g; m_we = g && bus.d_we;
    end
    check("mem_en", bus.mem_en, e_en);
    check("mem_we", bus.mem_we, e_we);
    check("mem_addr", bus.mem_addr, e_addr);
    check("mem_wdata", bus.mem_wdata, e_wd);
    check("i_ack", bus.i_ack, e_ia);
    check("i_rdata", bus.i_rdata, e_ir);
    check("d_ack", bus.d_ack, e_da);
    check("d_rdata", bus.d_rdata, e_dr);
    check("dual_ack", bus.i_ack & bus.d_ack, 0);
  end

  initial begin
    logic a;
    rst = 1'b1;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
    repeat (3) tick;
    #3;
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_acks", {bus.i_ack, bus.d_ack}, 0);

    // Single fetch: issue, then ack with routed data.
    do_reset;
    #3;
    check("idle_mem_addr", bus.mem_addr, 0);
    tick;
    bus.i_req = 1; bus.i_addr = 32'h10;
    #3;
    check("fetch_en", bus.mem_en, 1);
    check("fetch_addr", bus.mem_addr, 32'h10);
    check("fetch_we", bus.mem_we, 0);
    tick;
    bus.mem_rdata = 32'h0050_0093;
    #3;
    check("fetch_ack", bus.i_ack, 1);
    check("fetch_rdata", bus.i_rdata, 32'h0050_0093);
    check("fetch_ack_en", bus.mem_en, 0);
    tick;
    bus.i_req = 0; bus.mem_rdata = 0;
    #3;
    check("fetch_ack_drop", bus.i_ack, 0);

    // Store: write strobe, ack carries no data.
    tick;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF;
    bus.mem_rdata = 32'h1234_5678;
    #3;
    check("store_we", bus.mem_we, 1);
    check("store_addr", bus.mem_addr, 32'h40);
    check("store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    tick;
    #3;
    check("store_ack", bus.d_ack, 1);
    check("store_rdata", bus.d_rdata, 0);
    tick;
    bus.d_req = 0; bus.d_we = 0;

    // Both ports held high: grant order.
    do_reset;
    bus.i_addr = 32'h100; bus.d_addr = 32'h200; bus.d_we = 0;
    bus.i_req = 1; bus.d_req = 1;
    gnt_log.delete();
    repeat (20) tick;
    check("gnt_count", gnt_log.size(), 10);
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_RR_EN
      check("gnt_order", (k < gnt_log.size()) ? gnt_log[k] : 32'hFFFF_FFFF,
            (k % 2 == 1) ? 32'h100 : 32'h200);
`else
      check("gnt_order", (k < gnt_log.size()) ? gnt_log[k] : 32'hFFFF_FFFF,
            (k % 5 == 4) ? 32'h100 : 32'h200);
`endif
    end
    bus.i_req = 0; bus.d_req = 0;
    tick;

    // Reset in the response cycle of a load discards the ack; request re-issues.
    do_reset;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
    #3;
    check("rr_issue", bus.mem_en, 1);
    tick;
    rst = 1; bus.mem_rdata = 32'hCAFE_0001;
    #3;
    check("rsp_rst_dack", bus.d_ack, 0);
    check("rsp_rst_drdata", bus.d_rdata, 0);
    check("rsp_rst_en", bus.mem_en, 0);
    tick;
    rst = 0;
    #3;
    check("reissue_en", bus.mem_en, 1);
    check("reissue_addr", bus.mem_addr, 32'h80);
    tick;
    #3;
    check("reissue_ack", bus.d_ack, 1);
    check("reissue_rdata", bus.d_rdata, 32'hCAFE_0001);
    tick;
    bus.d_req = 0;

    // Back-to-back loads: strobe on alternate cycles only.
    do_reset;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
    for (int k = 0; k < 12; k++) begin
      #3;
      check("b2b_en", bus.mem_en, (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) check("b2b_addr", bus.mem_addr, 32'h300 + 32'(4 * (k / 2)));
      a = bus.d_ack;
      tick;
      if (a) bus.d_addr = bus.d_addr + 32'h4;
    end
    bus.d_req = 0;
    tick;

    // Random traffic with occasional reset pulses; checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      if (!bus.i_req || seen_i_ack) begin
        bus.i_req = ($urandom % 3) != 0;
        bus.i_addr = $urandom;
      end
      if (!bus.d_req || seen_d_ack) begin
        bus.d_req = ($urandom % 3) != 0;
        bus.d_we = $urandom % 2;
        bus.d_addr = $urandom;
        bus.d_wdata = $urandom;
      end
      bus.mem_rdata = $urandom;
      rst = ($urandom % 60) == 0;
      tick;
    end
    rst = 0; bus.i_req = 0; bus.d_req = 0;
    repeat (3) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
